// File: rtl/msg_transmitter.sv
// Transmit-side message framer: buffers host bytes, streams them with boundary pulses,
// then waits a bounded time for the receiver's acknowledge.
module msg_transmitter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MIN_LEN     = 2,
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              send,
  output logic              busy,
  output logic              full,
  output logic              ovf_err,
  output logic              len_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld,
  output logic              bnd_plse,
  input  logic              ack,
  output logic              done,
  output logic              timeout_err
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);
  localparam int unsigned PtrW = $clog2(MAX_LEN);
  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LEN);
  localparam logic [CntW-1:0] MinCnt = CntW'(MIN_LEN);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StXmit, StWaitAck} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d, len_q, len_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              ovf_q, ovf_d, busy_q, busy_d, full_q, full_d;
  logic              len_err_q, len_err_d, done_q, done_d, tmo_err_q, tmo_err_d;
  logic              vld_q, vld_d, bnd_q, bnd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q [MAX_LEN];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tmo_d     = tmo_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    len_err_d = 1'b0;
    done_d    = 1'b0;
    tmo_err_d = 1'b0;
    vld_d     = 1'b0;
    bnd_d     = 1'b0;
    data_d    = '0;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_en) begin
          if (count_q < MaxCnt) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            count_d  = count_q + CntW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        // Length check sees the count including a same-cycle write.
        if (send) begin
          if (count_d < MinCnt) begin
            len_err_d = 1'b1;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
          end else begin
            len_d    = count_d;
            ovf_d    = 1'b0;
            busy_d   = 1'b1;
            rd_ptr_d = '0;
            state_d  = StXmit;
          end
        end
      end
      StXmit: begin
        data_d = mem_q[rd_ptr_q];
        vld_d  = 1'b1;
        bnd_d  = (rd_ptr_q == '0) || (CntW'(rd_ptr_q) == len_q - CntW'(1));
        if (CntW'(rd_ptr_q) == len_q - CntW'(1)) begin
          tmo_d   = '0;
          state_d = StWaitAck;
        end else begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
      end
      StWaitAck: begin
        // Ack on the cycle the counter hits the limit still wins over the timeout.
        if (ack || tmo_q == TmoMax) begin
          done_d    = ack;
          tmo_err_d = !ack;
          busy_d    = 1'b0;
          count_d   = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    full_d = (count_d == MaxCnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      len_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tmo_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      len_err_q <= 1'b0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      vld_q     <= 1'b0;
      bnd_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      len_q     <= len_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      full_q    <= full_d;
      len_err_q <= len_err_d;
      done_q    <= done_d;
      tmo_err_q <= tmo_err_d;
      vld_q     <= vld_d;
      bnd_q     <= bnd_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign busy        = busy_q;
  assign full        = full_q;
  assign ovf_err     = ovf_q;
  assign len_err     = len_err_q;
  assign data_out    = data_q;
  assign data_vld    = vld_q;
  assign bnd_plse    = bnd_q;
  assign done        = done_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: doc/msg_transmitter.md
Name: msg_transmitter

Overview:
- Transmit-side message framer for the message-receiver DUT. It is the other end of the data/bnd_plse/ack link.
- A host loads payload bytes into an internal buffer, then issues `send`.
- The block streams the bytes onto the link, marking the first and last byte with `bnd_plse`, then waits for the receiver's `ack`.
- It is used as a driver-side reference and as a synthesizable source for loopback benches.

Parameters:
- DATA_W, 8, width of payload byte and `data_out`.
- MIN_LEN, 2, minimum legal payload length in bytes.
- MAX_LEN, 32, maximum payload length in bytes; equals buffer depth.
- ACK_TIMEOUT, 16, cycles to wait for `ack` after the last byte.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  host write strobe: store `wr_data` into the buffer.
- wr_data  in  DATA_W  host payload byte.
- send  in  1  host request to transmit the buffered message.
- busy  out  1  high from send acceptance until return to IDLE.
- full  out  1  buffer holds MAX_LEN bytes.
- ovf_err  out  1  sticky: a write was dropped because the buffer was full.
- len_err  out  1  one-cycle pulse: `send` was rejected because count < MIN_LEN.
- data_out  out  DATA_W  link byte to the receiver.
- data_vld  out  1  `data_out` is valid this cycle.
- bnd_plse  out  1  boundary pulse, high with the first and with the last byte of a message.
- ack  in  1  receiver acknowledge.
- done  out  1  one-cycle pulse: message acknowledged.
- timeout_err  out  1  one-cycle pulse: no `ack` within ACK_TIMEOUT.

Behaviour:
- Reset (reset=1 at a rising edge):
  - All outputs go to 0.
  - count, wr_ptr, rd_ptr and the timeout counter go to 0; `ovf_err` is cleared.
  - State becomes IDLE. Reset overrides every other input.
  - Reset mid-transmission aborts the message: no `done`, no error pulse, buffer emptied.
- Registered outputs; states are IDLE, XMIT and WAIT_ACK.
- IDLE:
  - `wr_en` with count < MAX_LEN: store at wr_ptr, count++.
  - `wr_en` with count == MAX_LEN: byte dropped, `ovf_err` set; count unchanged.
  - `full` = (count == MAX_LEN), updated the cycle after the write.
  - `send`:
    - If count (including a same-cycle write) < MIN_LEN: `len_err` pulses the next cycle, the buffer is cleared, state stays IDLE.
    - Otherwise: latch len = count, clear `ovf_err`, `busy`=1, go to XMIT.
  - Same-cycle `wr_en` + `send`: the write is applied first, then the length check uses the updated count.
- XMIT:
  - Byte k (k = 0..len-1) is driven in the cycle after the previous one.
  - Latency: `send` sampled at edge N → byte 0 on `data_out` with `data_vld`=1 after edge N+1. Byte len-1 appears after edge N+len.
  - `bnd_plse`=1 when rd_ptr==0 or rd_ptr==len-1. With len==1 (only if MIN_LEN=1) it is a single pulse.
  - `wr_en`, `send` and `ack` are ignored during XMIT; ignored writes do not set `ovf_err`.
  - After the last byte, go to WAIT_ACK; `data_vld`, `bnd_plse` and `data_out` return to 0.
- WAIT_ACK:
  - The timeout counter starts at 0 on entry and increments each cycle.
  - `ack`=1 on a cycle with counter < ACK_TIMEOUT: `done` pulses the next cycle, the buffer is cleared, `busy`=0, state goes to IDLE.
  - If the counter reaches ACK_TIMEOUT with no `ack`: `timeout_err` pulses, the buffer is cleared, state goes to IDLE.
  - `ack` on the same cycle the counter reaches ACK_TIMEOUT counts as a success (`done`, no `timeout_err`).
  - Further `ack` pulses in IDLE are ignored.
- Width rules:
  - count is $clog2(MAX_LEN+1) bits.
  - Pointers are $clog2(MAX_LEN) bits and never wrap within a message; both are reset to 0 on every buffer clear.
- `data_out` is 0 whenever `data_vld`=0.

Test Plan:
- Sanity: write 4 bytes 0x11,0x22,0x33,0x44; `send`.
  - Required: 0x11..0x44 on consecutive cycles starting 1 cycle after `send`.
  - `bnd_plse` high on 0x11 and on 0x44 only.
  - `ack` 2 cycles later → `done` pulse; `busy` low.
- MAX payload: write 32 bytes 0x00..0x1F; `send`.
  - Required: `full`=1 before `send`; 32 valid cycles; `bnd_plse` on 0x00 and 0x1F; `done` after `ack`.
- MIN and undersize: 2 bytes → `bnd_plse` on both bytes.
  - 1 byte + `send` → `len_err` pulse, no `data_vld`, count back to 0.
  - `send` with an empty buffer → `len_err`.
- Buffer overflow: 33 writes.
  - Required: 33rd byte dropped, `ovf_err`=1 and held.
  - `send` transmits exactly 32 bytes; `ovf_err` clears on send acceptance.
- Ack/timeout coincidence:
  - No `ack` → `timeout_err` exactly ACK_TIMEOUT cycles after WAIT_ACK entry.
  - `ack` on the final timeout cycle → `done`, no `timeout_err`.
  - `ack` during XMIT → ignored.
- Reset mid-message: assert `reset` during byte 5 of 10.
  - Required: next cycle all outputs 0, no `done`.
  - A new 3-byte message sent afterwards transmits correctly.
